// File: rtl/mem_responder_if.sv
// Request/response bundle between a datapath and mem_responder.
// The master issues req/we/size/addr/wdata; the slave answers busy/done/err/rdata.
interface mem_responder_if;
   logic        req;
   logic        we;
   logic [1:0]  size;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        busy;
   logic        done;
   logic        err;
   logic [31:0] rdata;

   modport master (
      output req, we, size, addr, wdata,
      input  busy, done, err, rdata
   );

   modport slave (
      input  req, we, size, addr, wdata,
      output busy, done, err, rdata
   );
endinterface

// File: rtl/mem_responder.sv
// Byte-addressed little-endian memory with fixed-latency single-request access.
// One request in flight; response is a one-cycle done pulse with err and rdata.
module mem_responder #(
   parameter int DEPTH_BYTES = 256,
   parameter int LATENCY     = 2
) (
   input logic           clk,
   input logic           rst,
   mem_responder_if.slave bus
);

   localparam int AW = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_t;

   typedef struct packed {
      logic        we;
      logic [1:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
   } req_t;

   state_t      state;
   req_t        cur;
   logic [3:0]  cnt;
   logic        done_q;
   logic        err_q;
   logic [31:0] rdata_q;

   logic [7:0]  mem [DEPTH_BYTES];

   req_t        op;
   logic        enter_resp;
   logic        op_err;
   logic        mem_we;
   logic [2:0]  nbytes;
   logic [32:0] end_addr;
   logic [AW-1:0] i0, i1, i2, i3;
   logic [31:0] rd_word;

   assign bus.busy  = (state != IDLE);
   assign bus.done  = done_q;
   assign bus.err   = err_q;
   assign bus.rdata = rdata_q;

   // Operand for the edge entering RESP: live inputs when skipping WAIT, else captured.
   always_comb begin
      op = cur;
      if (state == IDLE) begin
         op.we    = bus.we;
         op.size  = bus.size;
         op.addr  = bus.addr;
         op.wdata = bus.wdata;
      end
   end

   // Legality check, 33-bit range so addresses near 2^32 cannot wrap.
   always_comb begin
      nbytes = 3'd0;
      unique case (op.size)
         2'b00:   nbytes = 3'd4;
         2'b01:   nbytes = 3'd2;
         2'b10:   nbytes = 3'd1;
         default: nbytes = 3'd0;
      endcase
      end_addr = {1'b0, op.addr} + {30'b0, nbytes};
      op_err = (op.size == 2'b11)
             || (op.size == 2'b00 && op.addr[1:0] != 2'b00)
             || (op.size == 2'b01 && op.addr[0])
             || (end_addr > 33'(DEPTH_BYTES));
   end

   // Byte lanes and zero-extended read data for the current operand.
   always_comb begin
      i0 = op.addr[AW-1:0];
      i1 = i0 + AW'(1);
      i2 = i0 + AW'(2);
      i3 = i0 + AW'(3);
      rd_word = 32'b0;
      unique case (op.size)
         2'b00:   rd_word = {mem[i3], mem[i2], mem[i1], mem[i0]};
         2'b01:   rd_word = {16'b0, mem[i1], mem[i0]};
         default: rd_word = {24'b0, mem[i0]};
      endcase
      enter_resp = (state == IDLE && bus.req && LATENCY == 1)
                || (state == WAIT && cnt == 4'd0);
      mem_we = rst && enter_resp && op.we && !op_err;
   end

   // Memory array; contents survive reset.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[i0] <= op.wdata[7:0];
         if (op.size != 2'b10) begin
            mem[i1] <= op.wdata[15:8];
         end
         if (op.size == 2'b00) begin
            mem[i2] <= op.wdata[23:16];
            mem[i3] <= op.wdata[31:24];
         end
      end
   end

   // Control FSM with registered done/err/rdata.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         cur     <= '0;
         cnt     <= 4'd0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         rdata_q <= 32'b0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         unique case (state)
            IDLE: begin
               if (bus.req) begin
                  cur <= op;
                  cnt <= 4'(LATENCY - 1);
                  state <= (LATENCY == 1) ? RESP : WAIT;
               end
            end
            WAIT: begin
               if (cnt == 4'd0) begin
                  state <= RESP;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            RESP: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
         if (enter_resp) begin
            done_q <= 1'b1;
            err_q  <= op_err;
            if (op_err) begin
               rdata_q <= 32'b0;
            end else if (!op.we) begin
               rdata_q <= rd_word;
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder (DEPTH_BYTES=256, LATENCY=2).
// Each step drives one request and checks busy/done/err/rdata edge by edge.
module tb_mem_responder;

   logic clk;
   logic rst;
   int   errors;
   int   checks;
   int   ndone;

   mem_responder_if bus ();

   mem_responder #(
      .DEPTH_BYTES(256),
      .LATENCY(2)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic xact(string tag, logic w, logic [1:0] sz,
                       logic [31:0] a, logic [31:0] wd,
                       logic e_err, logic [31:0] e_rd);
      @(negedge clk);
      bus.req   = 1'b1;
      bus.we    = w;
      bus.size  = sz;
      bus.addr  = a;
      bus.wdata = wd;
      @(posedge clk);
      #1;
      check({tag, "/busy_acc"}, 32'(bus.busy), 32'd1);
      check({tag, "/done_acc"}, 32'(bus.done), 32'd0);
      @(negedge clk);
      bus.req = 1'b0;
      @(posedge clk);
      #1;
      check({tag, "/done_wait"}, 32'(bus.done), 32'd0);
      @(posedge clk);
      #1;
      check({tag, "/done"}, 32'(bus.done), 32'd1);
      check({tag, "/err"}, 32'(bus.err), 32'(e_err));
      check({tag, "/rdata"}, bus.rdata, e_rd);
      @(posedge clk);
      #1;
      check({tag, "/done_end"}, 32'(bus.done), 32'd0);
      check({tag, "/busy_end"}, 32'(bus.busy), 32'd0);
   endtask

   initial begin
      logic [7:0] exp_busy;
      logic [7:0] exp_done;
      errors = 0;
      checks = 0;
      ndone  = 0;
      bus.req   = 1'b0;
      bus.we    = 1'b0;
      bus.size  = 2'b00;
      bus.addr  = 32'h0;
      bus.wdata = 32'h0;
      rst = 1'b1;
      #1 rst = 1'b0;
      #1;
      check("rst/busy", 32'(bus.busy), 32'd0);
      check("rst/done", 32'(bus.done), 32'd0);
      check("rst/err", 32'(bus.err), 32'd0);
      check("rst/rdata", bus.rdata, 32'd0);
      bus.req = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst/req_ignored", 32'(bus.busy), 32'd0);
      @(negedge clk);
      bus.req = 1'b0;
      rst = 1'b1;

      xact("wr_w10", 1, 2'b00, 32'h10, 32'hDEADBEEF, 0, 32'h0);
      xact("rd_w10", 0, 2'b00, 32'h10, 32'h0, 0, 32'hDEADBEEF);
      xact("wr_b11", 1, 2'b10, 32'h11, 32'h000000AA, 0, 32'hDEADBEEF);
      xact("rd_w10b", 0, 2'b00, 32'h10, 32'h0, 0, 32'hDEADAAEF);
      xact("rd_h12", 0, 2'b01, 32'h12, 32'h0, 0, 32'h0000DEAD);
      xact("rd_w12_mis", 0, 2'b00, 32'h12, 32'h0, 1, 32'h0);
      xact("rd_h13_mis", 0, 2'b01, 32'h13, 32'h0, 1, 32'h0);
      xact("rd_w10c", 0, 2'b00, 32'h10, 32'h0, 0, 32'hDEADAAEF);
      xact("wr_wFC", 1, 2'b00, 32'hFC, 32'h11223344, 0, 32'hDEADAAEF);
      xact("wr_w100", 1, 2'b00, 32'h100, 32'h55667788, 1, 32'h0);
      xact("wr_wtop", 1, 2'b00, 32'hFFFFFFFC, 32'h55667788, 1, 32'h0);
      xact("rd_wFC", 0, 2'b00, 32'hFC, 32'h0, 0, 32'h11223344);
      xact("rd_sz11", 0, 2'b11, 32'h10, 32'h0, 1, 32'h0);
      xact("rd_b13", 0, 2'b10, 32'h13, 32'h0, 0, 32'h000000DE);
      xact("rd_bFF", 0, 2'b10, 32'hFF, 32'h0, 0, 32'h00000011);
      xact("rd_wtop", 0, 2'b00, 32'hFFFFFFFC, 32'h0, 1, 32'h0);

      // req held high for six edges: accepts at edges 0 and 4.
      exp_busy = 8'b0111_0111;
      exp_done = 8'b0100_0100;
      @(negedge clk);
      bus.req  = 1'b1;
      bus.we   = 1'b0;
      bus.size = 2'b00;
      bus.addr = 32'h10;
      for (int k = 0; k < 8; k++) begin
         @(posedge clk);
         #1;
         check($sformatf("hold/busy%0d", k), 32'(bus.busy), 32'(exp_busy[k]));
         check($sformatf("hold/done%0d", k), 32'(bus.done), 32'(exp_done[k]));
         if (bus.done) ndone++;
         if (k == 0) bus.addr = 32'hFC;
         if (k == 2) begin
            check("hold/err2", 32'(bus.err), 32'd0);
            check("hold/rdata2", bus.rdata, 32'hDEADAAEF);
         end
         if (k == 5) bus.req = 1'b0;
         if (k == 6) check("hold/rdata6", bus.rdata, 32'h11223344);
      end
      check("hold/ndone", 32'(ndone), 32'd2);

      // Reset during WAIT of a write drops the write.
      xact("wr_w20", 1, 2'b00, 32'h20, 32'hCAFEF00D, 0, 32'h11223344);
      xact("rd_w20", 0, 2'b00, 32'h20, 32'h0, 0, 32'hCAFEF00D);
      @(negedge clk);
      bus.req   = 1'b1;
      bus.we    = 1'b1;
      bus.size  = 2'b00;
      bus.addr  = 32'h20;
      bus.wdata = 32'h12345678;
      @(posedge clk);
      #1;
      check("rstw/busy_acc", 32'(bus.busy), 32'd1);
      @(negedge clk);
      bus.req = 1'b0;
      #2 rst = 1'b0;
      #1;
      check("rstw/busy", 32'(bus.busy), 32'd0);
      check("rstw/done", 32'(bus.done), 32'd0);
      check("rstw/rdata", bus.rdata, 32'h0);
      ndone = 0;
      repeat (3) begin
         @(posedge clk);
         #1;
         if (bus.done) ndone++;
      end
      check("rstw/no_done", 32'(ndone), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      xact("rd_w20_kept", 0, 2'b00, 32'h20, 32'h0, 0, 32'hCAFEF00D);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
